// File: rtl/rmii_rx_deframer_pkg.sv
// RMII receive deframer shared definitions.
// FSM state encoding and preamble/SFD dibit values.
package rmii_rx_deframer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PRE  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  localparam logic [1:0] PRE_DIBIT = 2'b01;
  localparam logic [1:0] SFD_DIBIT = 2'b11;

endpackage

// File: rtl/rmii_rx_sample_gen.sv
// RMII dibit sample strobe: latches speed in IDLE and, at 10 Mb/s,
// aligns a decimation counter to the carrier edge to hit dibit centres.
module rmii_rx_sample_gen #(
  parameter int DECIM_10M = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic speed_100,
  input  logic crs_dv,
  input  logic idle,
  output logic samp
);

  localparam int CW = $clog2(DECIM_10M + 1);
  localparam logic [CW-1:0] HALF = CW'(DECIM_10M / 2);
  localparam logic [CW-1:0] WRAP = CW'(DECIM_10M - 1);

  logic          spd_q;
  logic          crs_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spd_q <= 1'b0;
      crs_q <= 1'b0;
      cnt   <= '0;
    end else begin
      crs_q <= crs_dv;
      if (idle)
        spd_q <= speed_100;
      if (idle && crs_dv && !crs_q)
        cnt <= '0;
      else if (cnt == WRAP)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
    end
  end

  assign samp = spd_q | (cnt == HALF);

endmodule

// File: rtl/rmii_rx_deframer.sv
// RMII receive deframer: preamble/SFD strip, LSB-first byte assembly.
// Optional saturating frame counters under RMII_RX_DEFRAMER_STATS_EN.
module rmii_rx_deframer
  import rmii_rx_deframer_pkg::*;
#(
  parameter int MAX_LEN   = 1522,
  parameter int DECIM_10M = 10
`ifdef RMII_RX_DEFRAMER_STATS_EN
 ,parameter int STAT_WIDTH = 16
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] rmii_rxd,
  input  logic       rmii_crs_dv,
  input  logic       rmii_rx_er,
  input  logic       speed_100,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  output logic       out_error,
  output logic       busy
`ifdef RMII_RX_DEFRAMER_STATS_EN
 ,output logic [STAT_WIDTH-1:0] stat_good,
  output logic [STAT_WIDTH-1:0] stat_bad
`endif
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_LEN - 1);

  logic [1:0]    state;
  logic [1:0]    idx;
  logic [CW-1:0] byte_cnt;
  logic          err;
  logic          seen01;
  logic          low_pend;
  logic          low_bad;
  logic [5:0]    asm_q;
  logic [7:0]    hold;
  logic          hold_full;
  logic          samp;

  rmii_rx_sample_gen #(
    .DECIM_10M (DECIM_10M)
  ) u_samp (
    .clk       (clk),
    .rst       (rst),
    .speed_100 (speed_100),
    .crs_dv    (rmii_crs_dv),
    .idle      (state == ST_IDLE),
    .samp      (samp)
  );

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      byte_cnt  <= '0;
      err       <= 1'b0;
      seen01    <= 1'b0;
      low_pend  <= 1'b0;
      low_bad   <= 1'b0;
      asm_q     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_error <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_error <= 1'b0;
      // Truncated frame: flush the held final byte as a bad last byte
      if (state == ST_DROP && hold_full) begin
        out_valid <= 1'b1;
        out_data  <= hold;
        out_last  <= 1'b1;
        out_error <= 1'b1;
        hold_full <= 1'b0;
      end
      if (samp) begin
        unique case (state)
          ST_IDLE: begin
            if (rmii_crs_dv) begin
              state  <= ST_PRE;
              seen01 <= 1'b0;
            end
          end
          ST_PRE: begin
            if (!rmii_crs_dv) begin
              state <= ST_IDLE;
            end else if (rmii_rxd == PRE_DIBIT) begin
              seen01 <= 1'b1;
            end else if (rmii_rxd == SFD_DIBIT && seen01) begin
              state    <= ST_DATA;
              idx      <= '0;
              byte_cnt <= '0;
              err      <= 1'b0;
              low_pend <= 1'b0;
            end else if (rmii_rxd != 2'b00) begin
              state    <= ST_DROP;
              low_pend <= 1'b0;
            end
          end
          ST_DATA: begin
            if (!rmii_crs_dv && low_pend) begin
              if (hold_full) begin
                out_valid <= 1'b1;
                out_data  <= hold;
                out_last  <= 1'b1;
                out_error <= err | rmii_rx_er | low_bad;
              end
              hold_full <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              // A lone low sample is CRS_DV toggling; keep its dibit
              low_pend <= !rmii_crs_dv;
              if (!rmii_crs_dv)
                low_bad <= idx[1];
              if (rmii_rx_er)
                err <= 1'b1;
              asm_q <= {rmii_rxd, asm_q[5:2]};
              idx   <= idx + 1'b1;
              if (idx == 2'd3) begin
                if (hold_full) begin
                  out_valid <= 1'b1;
                  out_data  <= hold;
                end
                hold      <= {rmii_rxd, asm_q};
                hold_full <= 1'b1;
                byte_cnt  <= byte_cnt + 1'b1;
                if (byte_cnt == LAST_CNT) begin
                  state    <= ST_DROP;
                  low_pend <= 1'b0;
                end
              end
            end
          end
          ST_DROP: begin
            if (!rmii_crs_dv && low_pend)
              state <= ST_IDLE;
            else
              low_pend <= !rmii_crs_dv;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef RMII_RX_DEFRAMER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_good <= '0;
      stat_bad  <= '0;
    end else if (out_valid && out_last) begin
      if (out_error) begin
        if (stat_bad != '1)
          stat_bad <= stat_bad + 1'b1;
      end else if (stat_good != '1) begin
        stat_good <= stat_good + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rmii_rx_deframer.sv
// Self-checking bench for rmii_rx_deframer: directed and random frames
// at both speeds checked against a frame-level reference model.
module tb_rmii_rx_deframer;

  localparam int MAXL = 1522;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] rmii_rxd = 2'b00;
  logic       rmii_crs_dv = 1'b0;
  logic       rmii_rx_er = 1'b0;
  logic       speed_100 = 1'b1;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_error;
  logic       busy;
`ifdef RMII_RX_DEFRAMER_STATS_EN
  logic [15:0] stat_good;
  logic [15:0] stat_bad;
`endif

  int total = 0;
  int bad = 0;
  int viol = 0;
  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];
  logic [7:0] frame_b[0:1599];

  always #10 clk = ~clk;

  rmii_rx_deframer #(
    .MAX_LEN   (MAXL),
    .DECIM_10M (10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rmii_rxd    (rmii_rxd),
    .rmii_crs_dv (rmii_crs_dv),
    .rmii_rx_er  (rmii_rx_er),
    .speed_100   (speed_100),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_last    (out_last),
    .out_error   (out_error),
    .busy        (busy)
`ifdef RMII_RX_DEFRAMER_STATS_EN
   ,.stat_good   (stat_good),
    .stat_bad    (stat_bad)
`endif
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid)
        got_q.push_back({out_last, out_error, out_data});
      else if (out_last || out_error)
        viol++;
    end
  end

  task automatic drive_dibit(input logic [1:0] d, input logic c,
                             input logic e);
    repeat (speed_100 ? 1 : 10) begin
      @(negedge clk);
      rmii_rxd    = d;
      rmii_crs_dv = c;
      rmii_rx_er  = e;
    end
  endtask

  task automatic idle_gap(input int n);
    repeat (n) drive_dibit(2'b00, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input int n, input int npre, input int er_d,
                            input int part, input bit tog);
    logic [7:0] b;
    logic       c;
    repeat (npre) drive_dibit(2'b01, 1'b1, 1'b0);
    drive_dibit(2'b11, 1'b1, 1'b0);
    for (int k = 0; k < n; k++) begin
      b = frame_b[k];
      for (int j = 0; j < 4; j++) begin
        c = (tog && k == n - 1) ? j[0] : 1'b1;
        drive_dibit(b[2*j +: 2], c, (k * 4 + j) == er_d);
      end
    end
    repeat (part) drive_dibit(2'($urandom), 1'b1, 1'b0);
  endtask

  // Frame-level model: every complete byte up to MAXL, last on the final
  // one, error for rx_er, a half-or-more partial byte, or truncation.
  function automatic void build_exp(input int n, input bit er,
                                    input int part);
    int  nb;
    bit  lst;
    exp_q.delete();
    nb = (n > MAXL) ? MAXL : n;
    for (int k = 0; k < nb; k++) begin
      lst = (k == nb - 1);
      exp_q.push_back({lst, lst && (er || part >= 2 || n > MAXL),
                       frame_b[k]});
    end
  endfunction

  task automatic run_frame(input bit spd, input int n, input int npre,
                           input int er_d, input int part, input bit tog);
    speed_100 = spd;
    idle_gap(3);
    got_q.delete();
    viol = 0;
    build_exp(n, er_d >= 0, part);
    send_frame(n, npre, er_d, part, tog);
    idle_gap(6);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid got=%b exp=0", out_valid);
    end
    total++;
    if ({out_last, out_error} !== 2'b00) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=00", {out_last, out_error});
    end
    total++;
    if (out_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_data got=%h exp=00", out_data);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, out_valid} !== 2'b00) begin
      bad++;
      $display("FAIL post_reset got=%b exp=00", {busy, out_valid});
    end
  endtask

  task automatic test_basic_100m;
    frame_b[0] = 8'h55;
    frame_b[1] = 8'hAA;
    frame_b[2] = 8'h0F;
    run_frame(1'b1, 3, 7, -1, 0, 1'b0);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL basic_cnt got=%0d exp=%0d",
               got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL basic_b%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if (viol != 0) begin
      bad++;
      $display("FAIL basic_flags got=%0d exp=0", viol);
    end
  endtask

  task automatic test_toggle;
    frame_b[0] = 8'hA5;
    frame_b[1] = 8'h3C;
    run_frame(1'b1, 2, 6, -1, 0, 1'b1);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL toggle_cnt got=%0d exp=%0d",
               got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL toggle_b%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_10m;
    frame_b[0] = 8'h12;
    frame_b[1] = 8'h34;
    run_frame(1'b0, 2, 7, -1, 0, 1'b0);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL s10m_cnt got=%0d exp=%0d",
               got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL s10m_b%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_rx_er;
    for (int k = 0; k < 4; k++) frame_b[k] = 8'($urandom);
    run_frame(1'b1, 4, 5, 6, 0, 1'b0);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL rxer_cnt got=%0d exp=%0d",
               got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL rxer_b%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_partial;
    for (int k = 0; k < 2; k++) frame_b[k] = 8'($urandom);
    run_frame(1'b1, 2, 4, -1, 2, 1'b0);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL part_cnt got=%0d exp=%0d",
               got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL part_b%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_truncate;
    int nerr;
`ifdef RMII_RX_DEFRAMER_STATS_EN
    logic [15:0] bad0;
    bad0 = stat_bad;
`endif
    nerr = 0;
    for (int k = 0; k < 1530; k++) frame_b[k] = 8'($urandom);
    speed_100 = 1'b1;
    idle_gap(3);
    got_q.delete();
    build_exp(1530, 1'b0, 0);
    send_frame(1530, 7, -1, 0, 1'b0);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL trunc_busy got=%b exp=1", busy);
    end
    idle_gap(6);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL trunc_idle got=%b exp=0", busy);
    end
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL trunc_cnt got=%0d exp=%0d",
               got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        nerr++;
        if (nerr < 5)
          $display("FAIL trunc_b%0d got=%h exp=%h",
                   i, got_q[i], exp_q[i]);
      end
    end
`ifdef RMII_RX_DEFRAMER_STATS_EN
    total++;
    if (stat_bad !== bad0 + 16'd1) begin
      bad++;
      $display("FAIL stat_bad got=%0d exp=%0d", stat_bad, bad0 + 16'd1);
    end
`endif
    frame_b[0] = 8'hC3;
    frame_b[1] = 8'h7E;
    run_frame(1'b1, 2, 7, -1, 0, 1'b0);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL after_cnt got=%0d exp=%0d",
               got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL after_b%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_mid_reset;
    speed_100 = 1'b1;
    idle_gap(3);
    got_q.delete();
    repeat (5) drive_dibit(2'b01, 1'b1, 1'b0);
    drive_dibit(2'b11, 1'b1, 1'b0);
    repeat (6) drive_dibit(2'($urandom), 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    rmii_crs_dv = 1'b0;
    rmii_rxd = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle_gap(4);
    total++;
    if (got_q.size() != 0) begin
      bad++;
      $display("FAIL midrst_out got=%0d exp=0", got_q.size());
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL midrst_busy got=%b exp=0", busy);
    end
    frame_b[0] = 8'h9D;
    run_frame(1'b1, 1, 4, -1, 0, 1'b0);
    total++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      bad++;
      $display("FAIL midrst_next got=%0d/%h exp=1/%h",
               got_q.size(), got_q.size() ? got_q[0] : 10'h0, exp_q[0]);
    end
  endtask

  task automatic test_random;
    bit spd;
    int n;
    int er_d;
    for (int r = 0; r < 12; r++) begin
      spd = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 16);
      for (int k = 0; k < n; k++) frame_b[k] = 8'($urandom);
      er_d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4 * n - 1) : -1;
      run_frame(spd, n, $urandom_range(2, 10), er_d,
                $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      total++;
      if (got_q.size() != exp_q.size()) begin
        bad++;
        $display("FAIL rnd%0d_cnt got=%0d exp=%0d",
                 r, got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
        total++;
        if (got_q[i] !== exp_q[i]) begin
          bad++;
          $display("FAIL rnd%0d_b%0d got=%h exp=%h",
                   r, i, got_q[i], exp_q[i]);
        end
      end
      total++;
      if (viol != 0) begin
        bad++;
        $display("FAIL rnd%0d_flags got=%0d exp=0", r, viol);
      end
    end
  endtask

  initial begin
    test_reset();
    test_truncate();
    test_basic_100m();
    test_toggle();
    test_10m();
    test_rx_er();
    test_partial();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50ms;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rmii_rx_deframer.md
Name: rmii_rx_deframer

Overview:
- Receive-side RMII front end running on the 50 MHz RMII reference clock (the same clock driven to the PHY as phy_ref_clk).
- Samples 2-bit RMII dibits from the PHY and resolves CRS_DV carrier/data-valid toggling.
- Strips preamble/SFD and assembles LSB-first bytes into a byte-strobe stream with last/error flags for the MAC receive path.
- Supports 100 Mb/s (every clock) and 10 Mb/s (each dibit held 10 clocks) operation.

Parameters:
- MAX_LEN, 1522: maximum frame length in bytes after SFD; longer frames are truncated and flagged.
- DECIM_10M, 10: clocks per dibit in 10 Mb/s mode.
- STAT_WIDTH, 16: width of the statistics counters (optional feature only).

Ports:
- clk  in  1  50 MHz RMII reference clock; only clock.
- rst  in  1  asynchronous, active-high reset.
- rmii_rxd  in  2  RMII receive dibit, bit0 first on wire.
- rmii_crs_dv  in  1  RMII carrier-sense/data-valid.
- rmii_rx_er  in  1  PHY receive error.
- speed_100  in  1  1 = 100 Mb/s, 0 = 10 Mb/s; latched only in IDLE.
- out_data  out  8  received byte.
- out_valid  out  1  one-cycle strobe per byte.
- out_last  out  1  qualifies out_valid: final byte of frame.
- out_error  out  1  qualifies out_last: frame bad (rx_er, misalignment, or truncation).
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset: all outputs 0; state IDLE; byte, dibit and decimation counters 0; hold register empty.
- Sample strobe (samp):
  - 100 Mb/s: samp every cycle.
  - 10 Mb/s: decimation counter cleared on the crs_dv 0→1 edge seen in IDLE. samp fires when the counter equals DECIM_10M/2, then every DECIM_10M clocks. The counter wraps at DECIM_10M-1.
- All state transitions below happen only on samp cycles.
- States:
  - IDLE: on crs_dv=1, go to PRE.
  - PRE: rxd=00 or 01 → stay. rxd=11 after ≥1 sample of 01 → DATA, clear dibit index, byte count and error flag. crs_dv=0 → IDLE with no output. rxd=10, or 11 without a preceding 01 → DROP.
  - DATA: each dibit is shifted into bits [2i+1:2i] of the assembly byte for i=0..3. On i=3 the byte is complete.
  - DROP: ignore input until carrier end, then IDLE. Nothing is emitted.
- Byte output and hold register:
  - Each completed byte enters a one-byte hold register.
  - If the hold register was full, its previous contents are emitted (out_valid=1, out_last=0).
  - Latency: byte N is emitted on the samp that completes byte N+1, or at frame end.
- Carrier end in DATA: crs_dv=0 on two consecutive samp cycles. A single low sample is PHY toggling; its dibit is still taken as data.
  - On carrier end, emit the held byte with out_last=1.
  - out_error=1 if rx_er was seen anywhere in DATA, or if the dibit index was not 0 or 1 at the first low sample (partial byte).
  - Go to IDLE.
  - If the hold register is empty (no complete byte), nothing is emitted.
- rx_er=1 on any DATA samp sets the sticky error flag.
- Byte count reaching MAX_LEN: emit byte MAX_LEN with out_last=1 and out_error=1, then go to DROP.
- At most one out_valid per clock; out_last and out_error are 0 whenever out_valid=0.
- Reset mid-frame: return to IDLE immediately; no output is emitted.
- speed_100 changes outside IDLE are ignored until the next IDLE.

Optional Feature:
- Macro: RMII_RX_DEFRAMER_STATS_EN.
- Defined: adds outputs stat_good[STAT_WIDTH-1:0] and stat_bad[STAT_WIDTH-1:0].
  - Each increments by 1 the cycle after an out_last with out_error=0 or 1 respectively.
  - Both saturate at all-ones and are reset to 0.
- Undefined: ports and logic are absent.

Decomposition:
- Shared package: state encoding (IDLE, PRE, DATA, DROP) and dibit constants PRE_DIBIT=2'b01, SFD_DIBIT=2'b11.
- One natural sub-module, rmii_rx_sample_gen: speed latch plus decimation counter producing samp.

Test Plan:
- 100M, 7×01 preamble then 11, bytes 0x55,0xAA,0x0F, crs_dv low two samples → three out_valid strobes, data 55/AA/0F, last only on 0F, error=0.
- 100M, crs_dv toggling 0/1 per dibit across the final byte 0x3C → 0x3C emitted with last=1, error=0; no premature end.
- 10M, frame bytes 0x12,0x34 → each dibit sampled once per 10 clocks at the centre; outputs 12, 34 with last on 34.
- rx_er pulsed mid-frame on a 4-byte frame → all 4 bytes emitted; the fourth has last=1, error=1.
- Frame ending after 2 dibits of byte 3 → bytes 1–2 emitted, byte 2 with last=1, error=1.
- 1530-byte frame (MAX_LEN=1522) → 1522 strobes, last/error on byte 1522, busy stays high until carrier end, then the next frame is received normally. With stats enabled, stat_bad=1.
